// File: rtl/skywave_rstctl.sv
// Skywave SoC reset controller: synchronises RESET# and PLL lock, filters lock, stretches reset and
// releases N domains in stagger order. Define SKYWAVE_RSTCTL_WDT_EN to add the watchdog (wdt_kick_i).
module skywave_rstctl #(
  parameter int unsigned N_DOMAINS      = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LOCK_FILTER    = 4,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned WDT_CYCLES     = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 pll_locked_i,
  input  logic [N_DOMAINS-1:0] sw_reset_req_i,
`ifdef SKYWAVE_RSTCTL_WDT_EN
  input  logic                 wdt_kick_i,
`endif
  output logic [N_DOMAINS-1:0] rst_o,
  output logic                 ready_o,
  output logic [1:0]           cause_o
);

  localparam int unsigned LOCK_W  = (LOCK_FILTER > 0) ? $clog2(LOCK_FILTER + 1) : 1;
  localparam int unsigned STR_W   = $clog2(STRETCH_CYCLES + 1);
  localparam int unsigned REL_MAX = (N_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int unsigned REL_W   = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;

  if (N_DOMAINS < 1 || SYNC_STAGES < 2 || STRETCH_CYCLES < 1 || STAGGER_CYCLES < 1 ||
      WDT_CYCLES < 1) begin : g_param_check
    $error("skywave_rstctl: illegal parameter value");
  end

  typedef enum logic [1:0] {WAIT_LOCK, STRETCH, RELEASE, RUN} state_e;

  state_e                          state_q, state_d;
  logic [SYNC_STAGES-1:0]          rst_sync_q, rst_sync_d;
  logic [SYNC_STAGES-1:0]          lk_sync_q, lk_sync_d;
  logic [LOCK_W-1:0]               lock_cnt_q, lock_cnt_d;
  logic [STR_W-1:0]                stretch_cnt_q, stretch_cnt_d;
  logic [REL_W-1:0]                rel_cnt_q, rel_cnt_d;
  logic [N_DOMAINS-1:0][STR_W-1:0] pcnt_q, pcnt_d;
  logic [N_DOMAINS-1:0]            armed_q, armed_d;
  logic [N_DOMAINS-1:0]            rst_q, rst_d;
  logic                            ready_q, ready_d;
  logic [1:0]                      cause_q, cause_d;
  logic [N_DOMAINS-1:0]            pulse_go;
  logic                            rel;
  logic                            lk;
  logic                            lock_lost;
  logic                            sw_full;
  logic                            wdt_fire;
`ifdef SKYWAVE_RSTCTL_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0]                wdt_cnt_q, wdt_cnt_d;
`endif

  assign rel = rst_sync_q[SYNC_STAGES-1];
  assign lk  = lk_sync_q[SYNC_STAGES-1];

  // Next-state and registered-output logic; events ranked lock loss > WDT > full soft > per-domain.
  always_comb begin
    state_d       = state_q;
    rst_sync_d    = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    lk_sync_d     = {lk_sync_q[SYNC_STAGES-2:0], pll_locked_i};
    lock_cnt_d    = '0;
    stretch_cnt_d = '0;
    rel_cnt_d     = '0;
    pcnt_d        = '0;
    pulse_go      = '0;
    cause_d       = cause_q;
    rst_d         = '1;
    ready_d       = 1'b0;
    armed_d       = rel ? (armed_q | ~sw_reset_req_i) : armed_q;
    lock_lost     = (state_q != WAIT_LOCK) && !lk;
    sw_full       = (state_q == RUN) && sw_reset_req_i[0];
    wdt_fire      = 1'b0;
`ifdef SKYWAVE_RSTCTL_WDT_EN
    wdt_cnt_d = '0;
    if (state_q == RUN && !wdt_kick_i) begin
      wdt_cnt_d = (32'(wdt_cnt_q) >= WDT_CYCLES) ? wdt_cnt_q : wdt_cnt_q + 1'b1;
    end
    wdt_fire = rel && (state_q == RUN) && (32'(wdt_cnt_d) >= WDT_CYCLES);
`endif

    if (!rel) begin
      state_d = WAIT_LOCK;
    end else if (lock_lost) begin
      state_d = WAIT_LOCK;
      cause_d = 2'b01;
    end else if (wdt_fire) begin
      state_d = STRETCH;
      cause_d = 2'b11;
    end else if (sw_full) begin
      state_d = STRETCH;
      cause_d = 2'b10;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          if (lk) begin
            lock_cnt_d = (lock_cnt_q == LOCK_W'(LOCK_FILTER)) ? lock_cnt_q : lock_cnt_q + 1'b1;
          end
          if (lk && (lock_cnt_d >= LOCK_W'(LOCK_FILTER))) begin
            state_d = STRETCH;
          end
        end
        STRETCH: begin
          if (32'(stretch_cnt_q) >= STRETCH_CYCLES - 1) begin
            state_d = (REL_MAX == 0) ? RUN : RELEASE;
          end else begin
            stretch_cnt_d = stretch_cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          rel_cnt_d = (32'(rel_cnt_q) < REL_MAX) ? rel_cnt_q + 1'b1 : rel_cnt_q;
          if (32'(rel_cnt_d) >= REL_MAX) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // Bit 0 is the full restart; only domains 1.. get an individual pulse.
          pulse_go = sw_reset_req_i & armed_q & ~N_DOMAINS'(1);
          armed_d  = armed_d & ~pulse_go;
          for (int unsigned k = 0; k < N_DOMAINS; k++) begin
            if (pulse_go[k]) begin
              pcnt_d[k] = STR_W'(STRETCH_CYCLES);
            end else if (pcnt_q[k] != '0) begin
              pcnt_d[k] = pcnt_q[k] - 1'b1;
            end
          end
          if (pulse_go != '0) begin
            cause_d = 2'b10;
          end
        end
        default: state_d = WAIT_LOCK;
      endcase
    end

`ifdef SKYWAVE_RSTCTL_WDT_EN
    if (state_d != RUN) begin
      wdt_cnt_d = '0;
    end
`endif

    unique case (state_d)
      RELEASE: begin
        for (int unsigned k = 0; k < N_DOMAINS; k++) begin
          rst_d[k] = 32'(rel_cnt_d) < k * STAGGER_CYCLES;
        end
      end
      RUN: begin
        for (int unsigned k = 0; k < N_DOMAINS; k++) begin
          rst_d[k] = pcnt_d[k] != '0;
        end
      end
      default: rst_d = '1;
    endcase
    ready_d = (state_d == RUN) && (rst_d == '0);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= WAIT_LOCK;
      rst_sync_q    <= '0;
      lk_sync_q     <= '0;
      lock_cnt_q    <= '0;
      stretch_cnt_q <= '0;
      rel_cnt_q     <= '0;
      pcnt_q        <= '0;
      armed_q       <= '0;
      rst_q         <= '1;
      ready_q       <= 1'b0;
      cause_q       <= 2'b00;
`ifdef SKYWAVE_RSTCTL_WDT_EN
      wdt_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rst_sync_q    <= rst_sync_d;
      lk_sync_q     <= lk_sync_d;
      lock_cnt_q    <= lock_cnt_d;
      stretch_cnt_q <= stretch_cnt_d;
      rel_cnt_q     <= rel_cnt_d;
      pcnt_q        <= pcnt_d;
      armed_q       <= armed_d;
      rst_q         <= rst_d;
      ready_q       <= ready_d;
      cause_q       <= cause_d;
`ifdef SKYWAVE_RSTCTL_WDT_EN
      wdt_cnt_q     <= wdt_cnt_d;
`endif
    end
  end

  assign rst_o   = rst_q;
  assign ready_o = ready_q;
  assign cause_o = cause_q;

endmodule

// File: tb/tb_skywave_rstctl.sv
// Bench for skywave_rstctl: directed vector table plus hand-written power-up, async-reset and
// (with SKYWAVE_RSTCTL_WDT_EN) watchdog sequences.
module tb_skywave_rstctl;

`ifdef SKYWAVE_RSTCTL_WDT_EN
  localparam int unsigned WDT = 32;
`else
  localparam int unsigned WDT = 1024;
`endif

  typedef struct {
    int unsigned cyc;
    logic        pll;
    logic [3:0]  sw;
    logic [3:0]  rst;
    logic        rdy;
    logic [1:0]  cause;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       pll_locked;
  logic [3:0] sw_req;
  logic       kick;
  logic [3:0] rst_o;
  logic       ready_o;
  logic [1:0] cause_o;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  skywave_rstctl #(
    .N_DOMAINS(4), .SYNC_STAGES(2), .LOCK_FILTER(4), .STRETCH_CYCLES(16),
    .STAGGER_CYCLES(8), .WDT_CYCLES(WDT)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .pll_locked_i  (pll_locked),
    .sw_reset_req_i(sw_req),
`ifdef SKYWAVE_RSTCTL_WDT_EN
    .wdt_kick_i    (kick),
`endif
    .rst_o         (rst_o),
    .ready_o       (ready_o),
    .cause_o       (cause_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] r, input logic rd, input logic [1:0] c);
    checks++;
    if (rst_o !== r || ready_o !== rd || cause_o !== c) begin
      errors++;
      $display("FAIL %s: got rst_o=%b ready_o=%b cause_o=%b, want rst_o=%b ready_o=%b cause_o=%b",
               name, rst_o, ready_o, cause_o, r, rd, c);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic add(input int unsigned c, input logic p, input logic [3:0] s,
                     input logic [3:0] r, input logic rd, input logic [1:0] ca);
    vec_t v;
    v.cyc = c; v.pll = p; v.sw = s; v.rst = r; v.rdy = rd; v.cause = ca;
    vecs.push_back(v);
  endtask

  // Negedges from reset release until rst_o[0] first falls (bounded).
  task automatic wait_release(output int n);
    n = 0;
    while (rst_o[0] && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    // Staggered release from t (rst_o[0] just fell)
    add(7, 1, 4'b0000, 4'b1110, 0, 2'b00);
    add(1, 1, 4'b0000, 4'b1100, 0, 2'b00);
    add(7, 1, 4'b0000, 4'b1100, 0, 2'b00);
    add(1, 1, 4'b0000, 4'b1000, 0, 2'b00);
    add(7, 1, 4'b0000, 4'b1000, 0, 2'b00);
    add(1, 1, 4'b0000, 4'b0000, 1, 2'b00);
    add(6, 1, 4'b0000, 4'b0000, 1, 2'b00);
    // Held per-domain request: one 16-cycle pulse, then two domains together
    add(1, 1, 4'b0100, 4'b0100, 0, 2'b10);
    add(15, 1, 4'b0100, 4'b0100, 0, 2'b10);
    add(1, 1, 4'b0100, 4'b0000, 1, 2'b10);
    add(23, 1, 4'b0100, 4'b0000, 1, 2'b10);
    add(1, 1, 4'b0000, 4'b0000, 1, 2'b10);
    add(1, 1, 4'b1010, 4'b1010, 0, 2'b10);
    add(15, 1, 4'b1010, 4'b1010, 0, 2'b10);
    add(1, 1, 4'b1010, 4'b0000, 1, 2'b10);
    add(1, 1, 4'b0000, 4'b0000, 1, 2'b10);
    // One-cycle lock drop in RUN and full recovery
    add(1, 0, 4'b0000, 4'b0000, 1, 2'b10);
    add(1, 1, 4'b0000, 4'b0000, 1, 2'b10);
    add(1, 1, 4'b0000, 4'b1111, 0, 2'b01);
    add(19, 1, 4'b0000, 4'b1111, 0, 2'b01);
    add(1, 1, 4'b0000, 4'b1110, 0, 2'b01);
    add(23, 1, 4'b0000, 4'b1000, 0, 2'b01);
    add(1, 1, 4'b0000, 4'b0000, 1, 2'b01);
    // Lock lost, then a 3-cycle lock blip that must not pass the filter
    add(3, 0, 4'b0000, 4'b1111, 0, 2'b01);
    add(10, 0, 4'b0000, 4'b1111, 0, 2'b01);
    add(3, 1, 4'b0000, 4'b1111, 0, 2'b01);
    add(30, 0, 4'b0000, 4'b1111, 0, 2'b01);
    add(21, 1, 4'b0000, 4'b1111, 0, 2'b01);
    add(1, 1, 4'b0000, 4'b1110, 0, 2'b01);
    add(24, 1, 4'b0000, 4'b0000, 1, 2'b01);
    // Full soft restart through bit 0
    add(1, 1, 4'b0001, 4'b1111, 0, 2'b10);
    add(15, 1, 4'b0000, 4'b1111, 0, 2'b10);
    add(1, 1, 4'b0000, 4'b1110, 0, 2'b10);
    add(24, 1, 4'b0000, 4'b0000, 1, 2'b10);
    // Bit 0 request and synced lock loss in the same cycle: lock loss wins
    add(1, 0, 4'b0000, 4'b0000, 1, 2'b10);
    add(1, 1, 4'b0000, 4'b0000, 1, 2'b10);
    add(1, 1, 4'b0001, 4'b1111, 0, 2'b01);
    add(1, 1, 4'b0000, 4'b1111, 0, 2'b01);
    add(18, 1, 4'b0000, 4'b1111, 0, 2'b01);
    add(1, 1, 4'b0000, 4'b1110, 0, 2'b01);
    add(24, 1, 4'b0000, 4'b0000, 1, 2'b01);

    reset_i    = 1'b0;
    pll_locked = 1'b1;
    sw_req     = 4'b0000;
    kick       = 1'b1;
    repeat (5) @(negedge clk);
    check("por_hold", 4'b1111, 1'b0, 2'b00);
    reset_i = 1'b1;
    wait_release(n);
    check_int("por_release_latency", n, 22);
    check("por_first_release", 4'b1110, 1'b0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      pll_locked = vecs[i].pll;
      sw_req     = vecs[i].sw;
      repeat (vecs[i].cyc) @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].rst, vecs[i].rdy, vecs[i].cause);
    end

`ifdef SKYWAVE_RSTCTL_WDT_EN
    kick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (19) @(negedge clk);
      kick = 1'b1;
      @(negedge clk);
      kick = 1'b0;
      check($sformatf("wdt_kicked%0d", i), 4'b0000, 1'b1, 2'b01);
    end
    n = 1;
    while (rst_o == 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_int("wdt_timeout_latency", n, 33);
    check("wdt_restart", 4'b1111, 1'b0, 2'b11);
    kick = 1'b1;
`endif

    // Asynchronous clear mid-cycle, then a second power-up
    #2 reset_i = 1'b0;
    #1 check("async_clear", 4'b1111, 1'b0, 2'b00);
    @(negedge clk);
    reset_i = 1'b1;
    wait_release(n);
    check_int("rerelease_latency", n, 22);
    check("rerelease_state", 4'b1110, 1'b0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
